seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per scanned word.
REQ-002 SHALL have parameter CW, default $clog2(WIDTH+1), meaning width of the match counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all controller state updates on posedge.
REQ-004 SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-005 SHALL have ports req0 and req1, input, 1 each, meaning level scan requests from requesters 0 and 1.
REQ-006 SHALL have ports data0 and data1, input, WIDTH each, meaning the word to scan, valid while the matching req is high.
REQ-007 SHALL have ports gnt0 and gnt1, output, 1 each, meaning a one-cycle grant pulse; data is latched on that edge.
REQ-008 SHALL have port busy, output, 1, meaning the controller is not in IDLE.
REQ-009 SHALL have port done, output, 1, meaning a one-cycle result-valid pulse.
REQ-010 SHALL have port owner, output, 1, meaning the requester id of the current or last scan.
REQ-011 SHALL have port count, output, CW, meaning the number of detector flags seen in the last scan.
REQ-012 SHALL have port det_din, output, 1, meaning the serial bit to the pattern detector.
REQ-013 SHALL have port det_rst_n, output, 1, meaning the detector's synchronous active-low reset.
REQ-014 SHALL have port det_flag, input, 1, meaning the detector match flag, registered by the detector on negedge clk.

Function
REQ-015 SHALL implement FSM states IDLE, CLR, SHIFT and DONE.
REQ-016 IDLE: on a posedge with any req high, SHALL grant one requester, latch its data into the shift register, set owner, clear count and bit counter, raise the matching gnt, and go to CLR.
REQ-017 Arbitration SHALL be round-robin on a last-granted pointer: if both requests are high, the requester not granted last wins; if only one is high, it wins.
REQ-018 CLR: SHALL last exactly one cycle with det_rst_n=0 and gnt deasserted at its end, then go to SHIFT.
REQ-019 SHIFT: SHALL last exactly WIDTH cycles, with det_din = shift-register MSB (data sent MSB first) and the register shifted left by one at each edge.
REQ-020 Flag counting: at every posedge that ends a SHIFT cycle, SHALL add det_flag to count, giving WIDTH samples; sample k corresponds to bit k.
REQ-021 After the WIDTH-th SHIFT edge, SHALL go to DONE.
REQ-022 DONE: SHALL hold done=1 for one cycle, then go to IDLE.
REQ-023 count and owner SHALL hold their values until the next grant.
REQ-024 det_rst_n SHALL be 1 only in SHIFT and 0 in all other states.
REQ-025 det_din SHALL be 0 outside SHIFT.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 Latency: done SHALL rise WIDTH+1 edges after gnt rises; the next grant SHALL occur no earlier than WIDTH+3 edges after the previous one.
REQ-028 Requests arriving while busy SHALL be ignored until IDLE; a requester that holds req after its grant SHALL be re-arbitrated normally.
REQ-029 count cannot overflow, since the maximum is WIDTH; no saturation logic SHALL be used.
REQ-030 All outputs SHALL be registered except det_din and busy, which SHALL be decoded directly from registered state.

Reset
REQ-031 While rst=1, SHALL asynchronously force: state=IDLE, gnt0=gnt1=0, done=0, busy=0, count=0, owner=0, det_din=0, det_rst_n=0.
REQ-032 While rst=1, SHALL set the last-granted pointer to 1 so that requester 0 wins the first tie.
REQ-033 Reset asserted mid-SHIFT SHALL abort the scan with no done pulse; the partial count SHALL be discarded.
REQ-034 Any FSM state outside the four defined states SHALL go to IDLE on the next edge.

Verification
REQ-035 req0=1, data0=16'hDDDD -> gnt0 pulse; done WIDTH+1 edges later with count=4, owner=0.
REQ-036 req1=1, data1=16'h6666 -> count=4, owner=1; det_din reproduces 0110 repeated, MSB first.
REQ-037 data0=16'hD000 -> count=1; data0=16'h0000 -> count=0; data0=16'hFFFF -> count=0.
REQ-038 req0 and req1 held high continuously -> grants alternate 0,1,0,1, with requester 0 granted first after reset.
REQ-039 rst pulsed at SHIFT cycle 7 -> immediate IDLE, det_rst_n=0, count=0, no done pulse; a fresh request then scans correctly.
REQ-040 req1 raised during a requester-0 scan -> ignored until IDLE, then granted; with the bench's model detector, det_rst_n is low for exactly one cycle before each SHIFT.

Source files
------------

// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: request/grant, scan-result and pattern-detector signals of the serial scan controller
interface seq_scan_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             req0, req1;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1, busy, done, owner;
    logic [CW-1:0]    count;
    logic             det_din, det_rst_n, det_flag;
    modport master (
        output req0, req1, data0, data1, det_flag,
        input  gnt0, gnt1, busy, done, owner, count, det_din, det_rst_n
    );
    modport slave (
        input  req0, req1, data0, data1, det_flag,
        output gnt0, gnt1, busy, done, owner, count, det_din, det_rst_n
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: round-robin arbitrated serial scan of a word through an external pattern detector, counting its flags
module seq_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            rst,
    seq_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_bits, r_count;
    logic             r_last, r_owner, r_gnt0, r_gnt1, r_done, r_det_rst_n;
    logic             w_pick;
    assign w_pick        = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done      = r_done;
    assign bus.owner     = r_owner;
    assign bus.count     = r_count;
    assign bus.det_rst_n = r_det_rst_n;
    assign bus.busy      = r_state != IDLE;
    assign bus.det_din   = (r_state == SHIFT) & r_sreg[WIDTH-1];
    // grant, clear the detector, shift the word out MSB first while counting flags, then pulse done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_bits      <= '0;
            r_count     <= '0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done      <= 1'b0;
            r_det_rst_n <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_det_rst_n <= 1'b0;
                    if (bus.req0 | bus.req1) begin
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_sreg  <= w_pick ? bus.data1 : bus.data0;
                        r_count <= '0;
                        r_bits  <= '0;
                        r_gnt0  <= ~w_pick;
                        r_gnt1  <= w_pick;
                        r_state <= CLR;
                    end
                end
                CLR: begin
                    r_det_rst_n <= 1'b1;
                    r_state     <= SHIFT;
                end
                SHIFT: begin
                    r_sreg  <= r_sreg << 1;
                    r_count <= r_count + CW'(bus.det_flag);
                    r_bits  <= r_bits + CW'(1);
                    if (r_bits == CW'(WIDTH - 1)) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_det_rst_n <= 1'b0;
                    end
                end
                DONE: r_state <= IDLE;
                default: begin
                    r_state     <= IDLE;
                    r_det_rst_n <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: scan controller bench with a "110" pattern detector model and a string-level count model
module tb_seq_scan_ctrl;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(WIDTH + 1);
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [1:0] det_hist;
    bit             s_ok;
    logic [1:0]     s_gv;
    int             s_lat, s_clr, s_nbits;
    logic [CW-1:0]  s_count;
    logic           s_owner;
    logic [WIDTH-1:0] s_bits;

    seq_scan_ctrl_if #(.WIDTH(WIDTH)) bus();
    seq_scan_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // detector: flags a "110" ending at the current bit, synchronous active-low reset, registered on negedge
    always @(negedge clk) begin
        if (!bus.det_rst_n) begin
            det_hist     <= 2'b00;
            bus.det_flag <= 1'b0;
        end else begin
            det_hist     <= {det_hist[0], bus.det_din};
            bus.det_flag <= ({det_hist, bus.det_din} == 3'b110);
        end
    end

    // number of positions k>=2 in the MSB-first bit string where bits k-2,k-1,k read 1,1,0
    function automatic int ref_count(input logic [WIDTH-1:0] d);
        int n = 0;
        for (int k = 2; k < WIDTH; k++)
            if (d[WIDTH+1-k] && d[WIDTH-k] && !d[WIDTH-1-k]) n++;
        return n;
    endfunction

    // request one scan from requester id, follow it to done and one cycle beyond
    task automatic do_scan(input bit id, input logic [WIDTH-1:0] d);
        int  g_cyc;
        bit  got = 0;
        if (id) begin bus.req1 = 1'b1; bus.data1 = d; end
        else    begin bus.req0 = 1'b1; bus.data0 = d; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            got = bus.gnt0 | bus.gnt1;
        end
        s_gv  = {bus.gnt1, bus.gnt0};
        g_cyc = cyc;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        s_bits = '0; s_nbits = 0; s_clr = 0; s_ok = 0;
        if (got) begin
            if (!bus.det_rst_n) s_clr++;
            for (int i = 0; i < 40 && !s_ok; i++) begin
                @(posedge clk); #1;
                if (bus.det_rst_n) begin
                    s_bits = {s_bits[WIDTH-2:0], bus.det_din};
                    s_nbits++;
                end else if (s_nbits == 0) s_clr++;
                if (bus.done) s_ok = 1;
            end
        end
        s_lat   = cyc - g_cyc;
        s_count = bus.count;
        s_owner = bus.owner;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data0 = 16'hDDDD; bus.data1 = 16'h6666;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.owner, bus.det_din, bus.det_rst_n, bus.count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt0/gnt1/busy/done/owner/din/rst_n/count = %b%b%b%b%b%b%b %0d, required all 0",
                     bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.owner, bus.det_din, bus.det_rst_n, bus.count);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_no_req: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_patterns();
        logic             ids  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [WIDTH-1:0] pats [5] = '{16'hDDDD, 16'h6666, 16'hD000, 16'h0000, 16'hFFFF};
        int               exps [5] = '{4, 4, 1, 0, 0};
        for (int t = 0; t < 5; t++) begin
            do_scan(ids[t], pats[t]);
            n_chk++;
            if (s_gv !== (ids[t] ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL pat%0d_grant: gnt1,gnt0=%b required %b", t, s_gv, ids[t] ? 2'b10 : 2'b01);
            end
            n_chk++;
            if (!s_ok || s_lat !== WIDTH + 1) begin
                n_fail++;
                $display("FAIL pat%0d_done_latency: seen=%0d edges=%0d required %0d", t, s_ok, s_lat, WIDTH + 1);
            end
            n_chk++;
            if (s_count !== CW'(exps[t]) || s_owner !== ids[t]) begin
                n_fail++;
                $display("FAIL pat%0d_result: count=%0d owner=%b required count=%0d owner=%b", t, s_count, s_owner, exps[t], ids[t]);
            end
            n_chk++;
            if (s_nbits !== WIDTH || s_bits !== pats[t]) begin
                n_fail++;
                $display("FAIL pat%0d_det_din: bits=%h n=%0d required %h n=%0d", t, s_bits, s_nbits, pats[t], WIDTH);
            end
            n_chk++;
            if (s_clr !== 1) begin
                n_fail++;
                $display("FAIL pat%0d_clr_cycles: det_rst_n low %0d cycles before shift, required 1", t, s_clr);
            end
            repeat (3) @(posedge clk);
            #1;
            n_chk++;
            if (bus.busy !== 1'b0 || bus.count !== CW'(exps[t]) || bus.owner !== ids[t]) begin
                n_fail++;
                $display("FAIL pat%0d_hold: busy=%b count=%0d owner=%b required 0 %0d %b", t, bus.busy, bus.count, bus.owner, exps[t], ids[t]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        bit got = 0;
        bit seen_done = 0;
        bus.req0 = 1'b1; bus.data0 = 16'hDDDD;
        for (int i = 0; i < 40 && !got; i++) begin @(posedge clk); #1; got = bus.gnt0; end
        bus.req0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_chk++;
        if (!got || bus.det_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_shift: granted=%0d det_rst_n=%b required 1 1", got, bus.det_rst_n);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.owner, bus.det_din, bus.det_rst_n, bus.count} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: gnt0/gnt1/busy/done/owner/din/rst_n/count = %b%b%b%b%b%b%b %0d, required all 0",
                     bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.owner, bus.det_din, bus.det_rst_n, bus.count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen_done = 1;
        end
        n_chk++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL midrst_no_done: done/busy activity after abort=1 required 0");
        end
        do_scan(1'b1, 16'h6666);
        n_chk++;
        if (!s_ok || s_count !== CW'(4) || s_owner !== 1'b1 || s_bits !== 16'h6666) begin
            n_fail++;
            $display("FAIL midrst_rescan: done=%0d count=%0d owner=%b bits=%h required 1 4 1 6666", s_ok, s_count, s_owner, s_bits);
        end
    endtask

    task automatic test_busy_ignore();
        int  g0 = -1, g1 = -1, dc = -1, clr = 0, nb = 0;
        bit  fin = 0;
        bus.req0 = 1'b1; bus.data0 = 16'hB6D3;
        for (int i = 0; i < 40 && g0 < 0; i++) begin @(posedge clk); #1; if (bus.gnt0) g0 = cyc; end
        bus.req0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.req1 = 1'b1; bus.data1 = 16'h6666;
        for (int i = 0; i < 40 && g1 < 0; i++) begin
            @(posedge clk); #1;
            if (bus.done && dc < 0) dc = cyc;
            if (bus.gnt1) g1 = cyc;
        end
        bus.req1 = 1'b0;
        n_chk++;
        if (g0 < 0 || dc !== g0 + WIDTH + 1 || g1 !== g0 + WIDTH + 3) begin
            n_fail++;
            $display("FAIL busy_ignore_timing: gnt0@%0d done@%0d gnt1@%0d required done=gnt0+%0d gnt1=gnt0+%0d", g0, dc, g1, WIDTH + 1, WIDTH + 3);
        end
        if (!bus.det_rst_n) clr++;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(posedge clk); #1;
            if (bus.det_rst_n) nb++;
            else if (nb == 0) clr++;
            if (bus.done) fin = 1;
        end
        n_chk++;
        if (!fin || clr !== 1 || bus.count !== CW'(ref_count(16'h6666)) || bus.owner !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_ignore_second: done=%0d clr=%0d count=%0d owner=%b required 1 1 %0d 1", fin, clr, bus.count, bus.owner, ref_count(16'h6666));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alternate();
        int gc[$];
        int gi[$];
        int prev;
        do_scan(1'b0, 16'h1234);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data0 = 16'hDDDD; bus.data1 = 16'h6666;
        for (int i = 0; i < 120 && gc.size() < 4; i++) begin
            @(posedge clk); #1;
            if (bus.gnt0 | bus.gnt1) begin gc.push_back(cyc); gi.push_back(int'(bus.gnt1)); end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        n_chk++;
        if (gc.size() !== 4) begin
            n_fail++;
            $display("FAIL alt_grant_count: grants=%0d required 4", gc.size());
        end
        prev = -1;
        foreach (gc[k]) begin
            n_chk++;
            if (gi[k] !== k % 2 || (k > 0 && gc[k] - prev !== WIDTH + 3)) begin
                n_fail++;
                $display("FAIL alt_grant%0d: id=%0d spacing=%0d required id=%0d spacing=%0d", k, gi[k], gc[k] - prev, k % 2, WIDTH + 3);
            end
            prev = gc[k];
        end
        for (int i = 0; i < 40 && bus.busy; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit               id;
        logic [WIDTH-1:0] d;
        for (int t = 0; t < 24; t++) begin
            id = 1'($urandom_range(0, 1));
            d  = WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) d = d | WIDTH'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_scan(id, d);
            n_chk++;
            if (!s_ok || s_lat !== WIDTH + 1 || s_gv !== (id ? 2'b10 : 2'b01) || s_owner !== id) begin
                n_fail++;
                $display("FAIL rnd%0d_handshake: done=%0d lat=%0d gnt=%b owner=%b required 1 %0d %b %b", t, s_ok, s_lat, s_gv, s_owner, WIDTH + 1, id ? 2'b10 : 2'b01, id);
            end
            n_chk++;
            if (s_count !== CW'(ref_count(d)) || s_bits !== d) begin
                n_fail++;
                $display("FAIL rnd%0d_result: data=%h count=%0d bits=%h required count=%0d bits=%h", t, d, s_count, s_bits, ref_count(d), d);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;
        test_reset();
        test_patterns();
        test_reset_mid_shift();
        test_busy_ignore();
        test_alternate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
